apb_cmd_master: RTL



---
 rtl/apb_master_pkg.sv | 30 +++
 rtl/apb_cmd_master_if.sv | 47 ++++
 rtl/apb_addr_decode.sv | 38 +++
 rtl/apb_cmd_master.sv | 176 +++++++++++++++++
 4 files changed

// File: rtl/apb_master_pkg.sv
// Shared types and defaults for the APB command master.
//   apb_mst_state_e : bus-phase state of the requester FSM
//   apb_rsp_err_e   : response error code returned on rsp_err
//   APB_SEL_LSB_DEF : default lowest address bit of the slave index field
//   APB_TIMEOUT_DEF : default ACCESS-phase wait budget before abort
//   sel_idx_width() : width of the slave index field for a given PSEL count
package apb_master_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SETUP,
    ST_ACCESS,
    ST_RESP
  } apb_mst_state_e;

  typedef enum logic [1:0] {
    RSP_OK      = 2'd0,
    RSP_SLVERR  = 2'd1,
    RSP_DECERR  = 2'd2,
    RSP_TIMEOUT = 2'd3
  } apb_rsp_err_e;

  localparam int unsigned APB_SEL_LSB_DEF = 10;
  localparam int unsigned APB_TIMEOUT_DEF = 16;

  function automatic int unsigned sel_idx_width(input int unsigned nslv);
    return (nslv > 2) ? $clog2(nslv) : 1;
  endfunction

endpackage

// File: rtl/apb_cmd_master_if.sv
// Command/response handshake plus APB bus bundle for apb_cmd_master.
//   cmd_*   : word command in (valid/ready)
//   rsp_*   : response out (valid/ready), rsp_err uses apb_rsp_err_e codes
//   P*      : APB requester signals; PREADY/PRDATA/PSLVERR are the muxed returns
// modport master : requester side (the apb_cmd_master instance)
// modport slave  : command source / response sink / APB completer side
interface apb_cmd_master_if #(
  parameter int unsigned AW   = 32,
  parameter int unsigned DW   = 32,
  parameter int unsigned SW   = 4,
  parameter int unsigned NSLV = 2
) ();
  logic            cmd_valid;
  logic            cmd_ready;
  logic [AW-1:0]   cmd_addr;
  logic            cmd_write;
  logic [DW-1:0]   cmd_wdata;
  logic [SW-1:0]   cmd_strb;
  logic            rsp_valid;
  logic            rsp_ready;
  logic [DW-1:0]   rsp_rdata;
  logic [1:0]      rsp_err;
  logic [AW-1:0]   PADDR;
  logic [NSLV-1:0] PSEL;
  logic            PENABLE;
  logic            PWRITE;
  logic [DW-1:0]   PWDATA;
  logic [SW-1:0]   PSTRB;
  logic [2:0]      PPROT;
  logic            PREADY;
  logic [DW-1:0]   PRDATA;
  logic            PSLVERR;

  modport master (
    input  cmd_valid, cmd_addr, cmd_write, cmd_wdata, cmd_strb, rsp_ready,
           PREADY, PRDATA, PSLVERR,
    output cmd_ready, rsp_valid, rsp_rdata, rsp_err,
           PADDR, PSEL, PENABLE, PWRITE, PWDATA, PSTRB, PPROT
  );

  modport slave (
    output cmd_valid, cmd_addr, cmd_write, cmd_wdata, cmd_strb, rsp_ready,
           PREADY, PRDATA, PSLVERR,
    input  cmd_ready, rsp_valid, rsp_rdata, rsp_err,
           PADDR, PSEL, PENABLE, PWRITE, PWDATA, PSTRB, PPROT
  );
endinterface

// File: rtl/apb_addr_decode.sv
// Combinational slave decode from a byte address.
//   cmd_addr : byte address
//   sel      : one-hot PSEL pattern, all zero on a decode error
//   dec_err  : address bits above the index field set, or index >= NSLV
module apb_addr_decode
  import apb_master_pkg::*;
#(
  parameter int unsigned AW      = 32,
  parameter int unsigned NSLV    = 2,
  parameter int unsigned SEL_LSB = APB_SEL_LSB_DEF
) (
  input  logic [AW-1:0]   cmd_addr,
  output logic [NSLV-1:0] sel,
  output logic            dec_err
);
  localparam int unsigned IW = sel_idx_width(NSLV);
  localparam int unsigned HI = SEL_LSB + IW;

  logic [IW-1:0] idx;
  logic          hi_set;
  logic          unused_addr;

  assign idx         = cmd_addr[SEL_LSB +: IW];
  // Offset bits below the index field do not take part in the decode.
  assign unused_addr = ^cmd_addr;

  if (HI < AW) begin : g_hi
    assign hi_set = |cmd_addr[AW-1:HI];
  end else begin : g_no_hi
    assign hi_set = 1'b0;
  end

  always_comb begin
    dec_err = hi_set || (32'(idx) >= NSLV);
    sel     = '0;
    if (!dec_err) sel[idx] = 1'b1;
  end
endmodule

// File: rtl/apb_cmd_master.sv
// APB requester: one outstanding word command at a time.
//   PCLK / PRESETn : clock, synchronous active-low reset
//   bus (master)   : cmd valid/ready in, rsp valid/ready out, APB requester
// All outputs are registered. rsp_rdata is zero for writes and all errors.
module apb_cmd_master
  import apb_master_pkg::*;
#(
  parameter int unsigned AW      = 32,
  parameter int unsigned DW      = 32,
  parameter int unsigned SW      = 4,
  parameter int unsigned NSLV    = 2,
  parameter int unsigned SEL_LSB = APB_SEL_LSB_DEF,
  parameter int unsigned TIMEOUT = APB_TIMEOUT_DEF
) (
  input  logic             PCLK,
  input  logic             PRESETn,
  apb_cmd_master_if.master bus
);
  localparam int unsigned CW = $clog2(TIMEOUT + 1);

  apb_mst_state_e  state_q, state_d;
  apb_rsp_err_e    rsp_err_q, rsp_err_d;
  logic            pend_q, pend_d;
  logic            cmd_ready_q, cmd_ready_d;
  logic            rsp_valid_q, rsp_valid_d;
  logic [DW-1:0]   rsp_rdata_q, rsp_rdata_d;
  logic [AW-1:0]   paddr_q, paddr_d;
  logic            pwrite_q, pwrite_d;
  logic [DW-1:0]   pwdata_q, pwdata_d;
  logic [SW-1:0]   pstrb_q, pstrb_d;
  logic [NSLV-1:0] psel_q, psel_d;
  logic            penable_q, penable_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [NSLV-1:0] dec_sel;
  logic            dec_err;

  // Decode runs on the latched address, so the cycle after accept is spent
  // in IDLE with pend_q set; this gives the 1-cycle DECERR and 3-cycle
  // zero-wait response latency while keeping every output registered.
  apb_addr_decode #(
    .AW      (AW),
    .NSLV    (NSLV),
    .SEL_LSB (SEL_LSB)
  ) u_dec (
    .cmd_addr (paddr_q),
    .sel      (dec_sel),
    .dec_err  (dec_err)
  );

  always_comb begin
    state_d     = state_q;
    pend_d      = pend_q;
    cmd_ready_d = cmd_ready_q;
    rsp_valid_d = rsp_valid_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;
    paddr_d     = paddr_q;
    pwrite_d    = pwrite_q;
    pwdata_d    = pwdata_q;
    pstrb_d     = pstrb_q;
    psel_d      = psel_q;
    penable_d   = penable_q;
    cnt_d       = cnt_q;

    unique case (state_q)
      ST_IDLE: begin
        if (pend_q) begin
          pend_d = 1'b0;
          if (dec_err) begin
            rsp_valid_d = 1'b1;
            rsp_err_d   = RSP_DECERR;
            rsp_rdata_d = '0;
            state_d     = ST_RESP;
          end else begin
            psel_d  = dec_sel;
            state_d = ST_SETUP;
          end
        end else if (bus.cmd_valid && cmd_ready_q) begin
          cmd_ready_d = 1'b0;
          pend_d      = 1'b1;
          paddr_d     = bus.cmd_addr;
          pwrite_d    = bus.cmd_write;
          pwdata_d    = bus.cmd_wdata;
          pstrb_d     = bus.cmd_write ? bus.cmd_strb : '0;
        end else begin
          cmd_ready_d = 1'b1;
        end
      end

      ST_SETUP: begin
        penable_d = 1'b1;
        cnt_d     = '0;
        state_d   = ST_ACCESS;
      end

      ST_ACCESS: begin
        if (bus.PREADY) begin
          psel_d      = '0;
          penable_d   = 1'b0;
          rsp_valid_d = 1'b1;
          state_d     = ST_RESP;
          if (bus.PSLVERR) begin
            rsp_err_d   = RSP_SLVERR;
            rsp_rdata_d = '0;
          end else begin
            rsp_err_d   = RSP_OK;
            rsp_rdata_d = pwrite_q ? '0 : bus.PRDATA;
          end
        end else if (cnt_q == CW'(TIMEOUT - 1)) begin
          psel_d      = '0;
          penable_d   = 1'b0;
          rsp_valid_d = 1'b1;
          rsp_err_d   = RSP_TIMEOUT;
          rsp_rdata_d = '0;
          state_d     = ST_RESP;
        end else if (cnt_q != CW'(TIMEOUT)) begin
          cnt_d = cnt_q + CW'(1);
        end
      end

      ST_RESP: begin
        if (bus.rsp_ready) begin
          rsp_valid_d = 1'b0;
          cmd_ready_d = 1'b1;
          state_d     = ST_IDLE;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge PCLK) begin
    if (!PRESETn) begin
      state_q     <= ST_IDLE;
      pend_q      <= 1'b0;
      cmd_ready_q <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= RSP_OK;
      paddr_q     <= '0;
      pwrite_q    <= 1'b0;
      pwdata_q    <= '0;
      pstrb_q     <= '0;
      psel_q      <= '0;
      penable_q   <= 1'b0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      pend_q      <= pend_d;
      cmd_ready_q <= cmd_ready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
      paddr_q     <= paddr_d;
      pwrite_q    <= pwrite_d;
      pwdata_q    <= pwdata_d;
      pstrb_q     <= pstrb_d;
      psel_q      <= psel_d;
      penable_q   <= penable_d;
      cnt_q       <= cnt_d;
    end
  end

  assign bus.cmd_ready = cmd_ready_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_rdata = rsp_rdata_q;
  assign bus.rsp_err   = rsp_err_q;
  assign bus.PADDR     = paddr_q;
  assign bus.PSEL      = psel_q;
  assign bus.PENABLE   = penable_q;
  assign bus.PWRITE    = pwrite_q;
  assign bus.PWDATA    = pwdata_q;
  assign bus.PSTRB     = pstrb_q;
  assign bus.PPROT     = 3'b000;
endmodule
